// File: rtl/kab_eic_pkg.sv
// Shared definitions for the Kabeta external interrupt controller:
// register map indices, FSM state encoding and STATUS field layout.
package kab_eic_pkg;

  localparam logic [1:0] EIC_REG_PEND   = 2'd0;
  localparam logic [1:0] EIC_REG_ENABLE = 2'd1;
  localparam logic [1:0] EIC_REG_STATUS = 2'd2;
  localparam logic [1:0] EIC_REG_RSVD   = 2'd3;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_ID_LSB   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } eic_state_e;

endpackage

// File: rtl/kab_eic_ctrl_if.sv
// IO-bus register port plus core interrupt handshake of the EIC.
// master = bus master / core side, slave = the controller.
interface kab_eic_ctrl_if #(
  parameter int unsigned ID_W = 3
);
  logic            Sys_WrEn;
  logic            Sys_RdEn;
  logic [1:0]      Sys_Address;
  logic [31:0]     Sys_WrData;
  logic [31:0]     Sys_RdData;
  logic            EIC_IntReq;
  logic [ID_W-1:0] EIC_IntId;
  logic            EIC_IntAck;

  modport master (
    output Sys_WrEn, Sys_RdEn, Sys_Address, Sys_WrData, EIC_IntAck,
    input  Sys_RdData, EIC_IntReq, EIC_IntId
  );

  modport slave (
    input  Sys_WrEn, Sys_RdEn, Sys_Address, Sys_WrData, EIC_IntAck,
    output Sys_RdData, EIC_IntReq, EIC_IntId
  );
endinterface

// File: rtl/kab_prio_enc.sv
// Fixed-priority encoder: lowest set bit index wins. Purely combinational.
module kab_prio_enc #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_SRC-1:0] vec,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  // Scan high to low so the last (lowest) hit overrides.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (vec[i-1]) idx = ID_W'(i - 1);
    end
  end

endmodule

// File: rtl/kab_eic_ctrl.sv
// Kabeta external interrupt controller: edge-latched pending bits, enable
// mask, fixed-priority selection and the core IntReq/IntId/IntAck handshake.
module kab_eic_ctrl
  import kab_eic_pkg::*;
#(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic             Sys_Clock,
  input  logic             Sys_Reset,
  input  logic [N_SRC-1:0] IntSrc,
  kab_eic_ctrl_if.slave    bus
);

  logic [N_SRC-1:0] prev_q, pend_q, enable_q;
  logic [N_SRC-1:0] rise, cand, id_onehot, w1c_mask, ack_mask;
  logic             cand_valid, load_id;
  logic [ID_W-1:0]  cand_id, id_q;
  logic [31:0]      rd_q, rd_d;
  eic_state_e       state_q, state_d;

  kab_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .vec   (cand),
    .valid (cand_valid),
    .idx   (cand_id)
  );

  // The bit being requested is protected from software W1C; only Ack clears it.
  always_comb begin
    rise      = IntSrc & ~prev_q;
    cand      = pend_q & enable_q;
    id_onehot = N_SRC'(1) << id_q;
    w1c_mask  = '0;
    if (bus.Sys_WrEn && bus.Sys_Address == EIC_REG_PEND)
      w1c_mask = bus.Sys_WrData[N_SRC-1:0];
    if (state_q == ST_REQ)
      w1c_mask = w1c_mask & ~id_onehot;
    ack_mask = (state_q == ST_REQ && bus.EIC_IntAck) ? id_onehot : '0;
  end

  always_comb begin
    state_d = state_q;
    load_id = 1'b0;
    case (state_q)
      ST_IDLE: if (cand_valid) begin
        load_id = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ:  if (bus.EIC_IntAck) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    if (bus.Sys_RdEn) begin
      rd_d = '0;
      case (bus.Sys_Address)
        EIC_REG_PEND:   rd_d = 32'(pend_q);
        EIC_REG_ENABLE: rd_d = 32'(enable_q);
        EIC_REG_STATUS: begin
          rd_d[STATUS_BUSY_BIT]          = (state_q != ST_IDLE);
          rd_d[STATUS_ID_LSB +: ID_W]    = id_q;
        end
        default:        rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge Sys_Clock) begin
    if (!Sys_Reset) begin
      prev_q   <= '0;
      pend_q   <= '0;
      enable_q <= '0;
      id_q     <= '0;
      rd_q     <= '0;
      state_q  <= ST_IDLE;
    end else begin
      prev_q  <= IntSrc;
      // A new rising edge wins over any clear in the same cycle.
      pend_q  <= (pend_q & ~(w1c_mask | ack_mask)) | rise;
      if (bus.Sys_WrEn && bus.Sys_Address == EIC_REG_ENABLE)
        enable_q <= bus.Sys_WrData[N_SRC-1:0];
      if (load_id)
        id_q <= cand_id;
      rd_q    <= rd_d;
      state_q <= state_d;
    end
  end

  assign bus.EIC_IntReq = (state_q == ST_REQ);
  assign bus.EIC_IntId  = id_q;
  assign bus.Sys_RdData = rd_q;

endmodule

// File: tb/tb_kab_eic_ctrl.sv
// Directed self-checking bench for kab_eic_ctrl (N_SRC=8, ID_W=3).
module tb_kab_eic_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] int_src;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [31:0] rd;

  kab_eic_ctrl_if #(.ID_W(3)) bus ();

  kab_eic_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .Sys_Clock (clk),
    .Sys_Reset (rst_n),
    .IntSrc    (int_src),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // All tasks start and end right after a negedge; the DUT acts on posedges.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.Sys_WrEn = 1'b1; bus.Sys_Address = a; bus.Sys_WrData = d;
    tick();
    bus.Sys_WrEn = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.Sys_RdEn = 1'b1; bus.Sys_Address = a;
    tick();
    bus.Sys_RdEn = 1'b0;
    d = bus.Sys_RdData;
  endtask

  task automatic ack_pulse();
    bus.EIC_IntAck = 1'b1;
    tick();
    bus.EIC_IntAck = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; int_src = 8'hFF;
    tick(3);
    rst_n = 1'b1; int_src = 8'h00;
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", bus.EIC_IntReq); end
    n_cmp++; if (bus.Sys_RdData !== 32'h0) begin n_err++; $display("FAIL reset_rddata got %h exp 0", bus.Sys_RdData); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_pend got %h exp 0", rd); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_status got %h exp 0", rd); end
  endtask

  task automatic test_single();
    bus_write(2'd1, 32'h04);
    int_src = 8'h04; tick(); int_src = 8'h00;
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL single_req_early got %b exp 0", bus.EIC_IntReq); end
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b1 || bus.EIC_IntId !== 3'd2) begin n_err++; $display("FAIL single_req got %b/%0d exp 1/2", bus.EIC_IntReq, bus.EIC_IntId); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h04) begin n_err++; $display("FAIL single_pend got %h exp 04", rd); end
    ack_pulse();
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL single_gap got %b exp 0", bus.EIC_IntReq); end
    tick(2);
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL single_stay_low got %b exp 0", bus.EIC_IntReq); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL single_pend_clr got %h exp 0", rd); end
  endtask

  task automatic test_priority();
    bus_write(2'd1, 32'hFF);
    int_src = 8'h28; tick(); int_src = 8'h00;
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b1 || bus.EIC_IntId !== 3'd3) begin n_err++; $display("FAIL prio_first got %b/%0d exp 1/3", bus.EIC_IntReq, bus.EIC_IntId); end
    ack_pulse();
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL prio_gap got %b exp 0", bus.EIC_IntReq); end
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL prio_idle got %b exp 0", bus.EIC_IntReq); end
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b1 || bus.EIC_IntId !== 3'd5) begin n_err++; $display("FAIL prio_second got %b/%0d exp 1/5", bus.EIC_IntReq, bus.EIC_IntId); end
    ack_pulse();
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL prio_pend_clr got %h exp 0", rd); end
  endtask

  task automatic test_masking();
    bus_write(2'd1, 32'h00);
    int_src = 8'h02; tick(); int_src = 8'h00;
    tick(2);
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL mask_noreq got %b exp 0", bus.EIC_IntReq); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h02) begin n_err++; $display("FAIL mask_pend got %h exp 02", rd); end
    bus_write(2'd1, 32'hFFFF_FF02);
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL mask_latency got %b exp 0", bus.EIC_IntReq); end
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b1 || bus.EIC_IntId !== 3'd1) begin n_err++; $display("FAIL mask_req got %b/%0d exp 1/1", bus.EIC_IntReq, bus.EIC_IntId); end
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'h02) begin n_err++; $display("FAIL mask_enable_rd got %h exp 02", rd); end
    ack_pulse();
    tick();
  endtask

  task automatic test_collisions();
    bus_write(2'd1, 32'h10);
    int_src = 8'h11; tick(); int_src = 8'h00;
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b1 || bus.EIC_IntId !== 3'd4) begin n_err++; $display("FAIL coll_req got %b/%0d exp 1/4", bus.EIC_IntReq, bus.EIC_IntId); end
    bus_write(2'd0, 32'h11);
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h10) begin n_err++; $display("FAIL coll_w1c got %h exp 10", rd); end
    n_cmp++; if (bus.EIC_IntReq !== 1'b1) begin n_err++; $display("FAIL coll_req_held got %b exp 1", bus.EIC_IntReq); end
    bus_read(2'd3, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL coll_rsvd got %h exp 0", rd); end
    int_src = 8'h10; ack_pulse(); int_src = 8'h00;
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL coll_gap got %b exp 0", bus.EIC_IntReq); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h10) begin n_err++; $display("FAIL coll_set_wins got %h exp 10", rd); end
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b1 || bus.EIC_IntId !== 3'd4) begin n_err++; $display("FAIL coll_rereq got %b/%0d exp 1/4", bus.EIC_IntReq, bus.EIC_IntId); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0000_0401) begin n_err++; $display("FAIL coll_status got %h exp 00000401", rd); end
    ack_pulse();
    tick();
  endtask

  task automatic test_stray_and_reset();
    ack_pulse();
    n_cmp++; if (bus.EIC_IntReq !== 1'b0) begin n_err++; $display("FAIL stray_req got %b exp 0", bus.EIC_IntReq); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0000_0400) begin n_err++; $display("FAIL stray_status got %h exp 00000400", rd); end
    int_src = 8'h10; tick(); int_src = 8'h00;
    tick();
    n_cmp++; if (bus.EIC_IntReq !== 1'b1) begin n_err++; $display("FAIL midrst_pre got %b exp 1", bus.EIC_IntReq); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_cmp++; if (bus.EIC_IntReq !== 1'b0 || bus.EIC_IntId !== 3'd0) begin n_err++; $display("FAIL midrst_req got %b/%0d exp 0/0", bus.EIC_IntReq, bus.EIC_IntId); end
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL midrst_enable got %h exp 0", rd); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL midrst_pend got %h exp 0", rd); end
  endtask

  initial begin
    rst_n = 1'b0; int_src = 8'h00;
    bus.Sys_WrEn = 1'b0; bus.Sys_RdEn = 1'b0; bus.Sys_Address = 2'd0;
    bus.Sys_WrData = 32'h0; bus.EIC_IntAck = 1'b0;
    tick();
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_collisions();
    test_stray_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
